// File: rtl/dram_host_port_pkg.sv
// Shared definitions for the data-RAM host port.
//   host_state_t : session state (IDLE, LOAD, RUN, RD, WAIT, OUT, DONE)
//   DEF_*        : default RAM geometry and load/dump region placement
package dram_host_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LOAD_BASE = 0;
  localparam int DEF_LOAD_LEN  = 265;   // 16x16 image + 3x3 kernel
  localparam int DEF_DUMP_BASE = 1024;
  localparam int DEF_DUMP_LEN  = 196;   // 14x14 result

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    RD   = 3'd3,
    WAIT = 3'd4,
    OUT  = 3'd5,
    DONE = 3'd6
  } host_state_t;

endpackage

// File: rtl/dram_host_port_if.sv
// Bus bundle between the host port and its surroundings (host streams,
// data RAM, processor control, status).
//   slave  : the dram_host_port side
//   master : host / RAM / processor side
interface dram_host_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) ();

  logic              start;
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;
  logic              ram_w_en;
  logic              ram_r_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              proc_en;
  logic              proc_finish;
  logic              busy;
  logic              done;

  modport slave (
    input  start, s_valid, s_data, m_ready, ram_rdata, proc_finish,
    output s_ready, m_valid, m_data, ram_w_en, ram_r_en, ram_addr,
           ram_wdata, proc_en, busy, done
  );

  modport master (
    output start, s_valid, s_data, m_ready, ram_rdata, proc_finish,
    input  s_ready, m_valid, m_data, ram_w_en, ram_r_en, ram_addr,
           ram_wdata, proc_en, busy, done
  );

endinterface

// File: rtl/dram_host_port_xfer_counter.sv
// Transfer counter shared by the load and dump phases.
//   clk, rst : clock, synchronous active-high reset
//   clr_i    : clear to zero (wins over inc_i)
//   inc_i    : increment by one
//   term_i   : index of the final transfer of the current phase
//   cnt_o    : current transfer index
//   last_o   : cnt_o equals term_i
module xfer_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == term_i);

endmodule

// File: rtl/dram_host_port.sv
// Host-side filler/drainer of the convolution processor's data RAM.
// Streams LOAD_LEN bytes into RAM, enables the processor until it reports
// finish, then reads DUMP_LEN result bytes back out to the host.
//   clk, rst : clock (shared with RAM), synchronous active-high reset
//   bus_io   : start, s_* input stream, m_* output stream, ram_* port,
//              proc_en/proc_finish, busy/done status
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | accepting input bytes, writing RAM
// RUN   | processor enabled, waiting for proc_finish
// RD    | RAM read strobe for the current result byte
// WAIT  | RAM data returns, captured into the m_data register
// OUT   | m_valid held until the host accepts
// DONE  | session complete, waiting for next start
module dram_host_port
  import dram_host_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LOAD_BASE = DEF_LOAD_BASE,
  parameter int LOAD_LEN  = DEF_LOAD_LEN,
  parameter int DUMP_BASE = DEF_DUMP_BASE,
  parameter int DUMP_LEN  = DEF_DUMP_LEN
) (
  input  logic             clk,
  input  logic             rst,
  dram_host_port_if.slave  bus_io
);

  localparam int MAX_LEN = (LOAD_LEN > DUMP_LEN) ? LOAD_LEN : DUMP_LEN;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  if (LOAD_LEN < 1 || DUMP_LEN < 1) begin : g_bad_len
    $error("dram_host_port: LOAD_LEN and DUMP_LEN must be at least 1");
  end
  if (longint'(LOAD_BASE) + longint'(LOAD_LEN) > (longint'(1) << ADDR_W)) begin : g_bad_load
    $error("dram_host_port: load region exceeds RAM address space");
  end
  if (longint'(DUMP_BASE) + longint'(DUMP_LEN) > (longint'(1) << ADDR_W)) begin : g_bad_dump
    $error("dram_host_port: dump region exceeds RAM address space");
  end

  host_state_t       state_q, state_d;
  logic [DATA_W-1:0] m_data_q;
  logic              cnt_clr, cnt_inc, cnt_last;
  logic [CNT_W-1:0]  cnt, cnt_term;
  logic              wr_fire;

  // One counter serves both phases; only the terminal index changes.
  assign cnt_term = (state_q == LOAD) ? CNT_W'(LOAD_LEN - 1) : CNT_W'(DUMP_LEN - 1);

  xfer_counter #(.W(CNT_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .term_i (cnt_term),
    .cnt_o  (cnt),
    .last_o (cnt_last)
  );

  // s_ready is high throughout LOAD, so a valid byte is always accepted.
  assign wr_fire = (state_q == LOAD) && bus_io.s_valid;

  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus_io.start) begin
          state_d = LOAD;
          cnt_clr = 1'b1;
        end
      end
      LOAD: begin
        if (bus_io.s_valid) begin
          if (cnt_last) begin
            state_d = RUN;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus_io.proc_finish) begin
          state_d = RD;
        end
      end
      RD:   state_d = WAIT;
      WAIT: state_d = OUT;
      OUT: begin
        if (bus_io.m_ready) begin
          cnt_inc = 1'b1;
          state_d = cnt_last ? DONE : RD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      m_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == WAIT) begin
        m_data_q <= bus_io.ram_rdata;
      end
    end
  end

  // Status and strobes decode the state register directly, so they change
  // only on clock edges; the LOAD write path is the one combinational route.
  assign bus_io.s_ready   = (state_q == LOAD);
  assign bus_io.proc_en   = (state_q == RUN);
  assign bus_io.ram_r_en  = (state_q == RD);
  assign bus_io.m_valid   = (state_q == OUT);
  assign bus_io.m_data    = m_data_q;
  assign bus_io.done      = (state_q == DONE);
  assign bus_io.busy      = (state_q != IDLE) && (state_q != DONE);
  assign bus_io.ram_w_en  = wr_fire;
  assign bus_io.ram_wdata = wr_fire ? bus_io.s_data : '0;

  always_comb begin
    bus_io.ram_addr = '0;
    if (wr_fire) begin
      bus_io.ram_addr = ADDR_W'(LOAD_BASE) + ADDR_W'(cnt);
    end else if (state_q == RD) begin
      bus_io.ram_addr = ADDR_W'(DUMP_BASE) + ADDR_W'(cnt);
    end
  end

endmodule
